// File: rtl/cache_mem_arbiter.sv
// Shares one physical-memory port between the icache and dcache, one full-line transaction at a time.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: dcache wins ties).
module cache_mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [2:0]        dbg_state
);

  // Handshake: a cache holds its request level until it sees a one-cycle x_resp,
  // then drops it within the following cycle; the memory answers a held strobe
  // with a single-cycle mem_resp. A request still high in IDLE starts a new line.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  state_t            state, state_next;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              i_req, d_req, tie_to_i, grant;

  assign i_req = i_read;
  assign d_req = d_read | d_write;
  assign grant = (state == IDLE) && (state_next != IDLE);

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = dcache was granted most recently; reset to 1 so the first tie goes to I.
  logic last_grant_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_d <= 1'b1;
    end else if (grant) begin
      last_grant_d <= (state_next == BUSY_D);
    end
  end

  assign tie_to_i = last_grant_d;
`else
  assign tie_to_i = 1'b0;
`endif

  always_comb begin
    state_next = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && d_req) state_next = tie_to_i ? BUSY_I : BUSY_D;
        else if (i_req)     state_next = BUSY_I;
        else if (d_req)     state_next = BUSY_D;
      end
      BUSY_I: begin
        mem_read = 1'b1;
        if (mem_resp) state_next = RESP_I;
      end
      BUSY_D: begin
        mem_read  = !op_write;
        mem_write = op_write;
        if (mem_resp) state_next = RESP_D;
      end
      RESP_I: begin
        i_resp     = 1'b1;
        state_next = IDLE;
      end
      RESP_D: begin
        d_resp     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The memory side sees only latched copies, so request inputs may wander mid-transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_write <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        addr_q   <= (state_next == BUSY_I) ? i_address : d_address;
        op_write <= (state_next == BUSY_D) && d_write;
        wdata_q  <= d_wdata;
      end
      if (state == BUSY_I && mem_resp) i_rdata <= mem_rdata;
      if (state == BUSY_D && mem_resp && !op_write) d_rdata <= mem_rdata;
    end
  end

  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign dbg_state   = state;

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

- Shares the single physical-memory port between the instruction cache (fetch side) and the data cache (memory stage).
- Each transaction is one full cache-line read or write.
- Latches the winning request and drives the memory port from registered state until the memory responds, then returns a one-cycle response pulse to the owning cache.
- Sits between the two caches and the cacheline adaptor / main memory.

## Interface

Parameters:
- LINE_W, 256, cache-line width in bits
- ADDR_W, 32, address width in bits

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-low
- i_read  in  1  icache line-fill request
- i_address  in  ADDR_W  icache line address
- i_rdata  out  LINE_W  line returned to icache
- i_resp  out  1  icache completion pulse
- d_read  in  1  dcache line-fill request
- d_write  in  1  dcache write-back request
- d_address  in  ADDR_W  dcache line address
- d_wdata  in  LINE_W  dcache write-back line
- d_rdata  out  LINE_W  line returned to dcache
- d_resp  out  1  dcache completion pulse
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_W  memory address
- mem_wdata  out  LINE_W  memory write line
- mem_rdata  in  LINE_W  memory read line
- mem_resp  in  1  memory completion, single-cycle pulse

## Operation

- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- **IDLE:** samples requests.
  - i only → BUSY_I.
  - d only → BUSY_D.
  - Both → tie rule (see Configuration).
  - On leaving IDLE, latch the request into registers:
    - the owner's address;
    - op = write iff d_write, else read;
    - the d_wdata line.
- **d_read and d_write both high:** treated as a write; d_write takes precedence.
- **BUSY_x:** mem_read/mem_write and mem_address/mem_wdata are driven only from the latched registers, never from live inputs. Changes on the request inputs during BUSY have no effect.
  - On mem_resp=1: capture mem_rdata into the owner's rdata register (reads only) and go to RESP_x.
- **RESP_x:** x_resp=1 for exactly one cycle; mem strobes are 0; next state is IDLE.
- **Request dropped mid-transaction:** the transaction still completes and x_resp still pulses.
- **i_rdata and d_rdata:** registered. Each holds its last captured line until the next read completion for that owner.
  - d_rdata is not updated by writes.
- **Reset values (rst=0, asynchronous):**
  - state = IDLE;
  - all strobes and resp = 0;
  - latched address, wdata, i_rdata, d_rdata = 0;
  - last_grant = D.
- **Reset mid-transaction:** the transaction is abandoned immediately; no resp is issued.
- **mem_resp outside BUSY:** ignored.

## Timing

- Request high in IDLE at cycle 0 → mem strobe high from cycle 1.
- mem_resp at cycle k → strobe low at k+1 and x_resp=1 at k+1, with rdata valid the same cycle.
- State is IDLE at k+2.
- The earliest next strobe is k+3.
- Minimum transaction is 3 cycles (mem_resp at cycle 1).
- The mem strobe is continuously high from grant until mem_resp.
- The caches must deassert their request within the cycle after x_resp. A request still high in IDLE starts a new transaction.

## Configuration

- Macro: ARB_ROUND_ROBIN_EN.
- **Defined:** on a tie, grant the requester that was not granted most recently (last_grant). last_grant updates on every grant.
  - The first tie after reset goes to I.
- **Undefined:** D always wins ties.
  - Fixed priority; the last_grant register is absent.

## Test plan

- **Lone icache read:**
  - Stimulus: i_read=1, i_address=0x0000_0060; memory returns 0xAA..AA with mem_resp 4 cycles after strobe.
  - Response: mem_read=1 with mem_address=0x60 from cycle 1; i_resp pulses once; i_rdata=0xAA..AA; d_resp stays 0.
- **Dcache write-back:**
  - Stimulus: d_write=1, d_address=0x0000_1000, d_wdata=0x5555..55.
  - Response: mem_write=1, mem_address=0x1000, mem_wdata=0x5555..55; d_resp pulses; d_rdata unchanged (0).
- **Tie, round-robin defined:**
  - Stimulus: i_read and d_read both held high from reset.
  - Response: grant order I, D, I, D across 4 transactions.
- **Tie, round-robin undefined:**
  - Stimulus: same as above.
  - Response: D first. After d_read drops, I is served.
- **Input change mid-transaction:**
  - Stimulus: during BUSY_I, change i_address to 0x200 and drop i_read.
  - Response: mem_address stays at the latched 0x60 until mem_resp; i_resp still pulses.
- **Reset mid-transaction:**
  - Stimulus: rst=0 during BUSY_D with no clock edge.
  - Response: mem_read/mem_write drop immediately; no d_resp; after release, a new request begins from IDLE.
